// File: rtl/axi_bram_responder.sv
// rtl/axi_bram_responder.sv - AXI4 responder backed by simple dual-port block RAM.
// Define AXI_BRAM_RESPONDER_DECERR_EN to answer out-of-range beats with DECERR.
module axi_bram_responder #(
    parameter int ID_W       = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_W-1:0]     awid,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + 32'd4;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_e           wstate_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q, wburst_q;
    logic [ID_W-1:0]   bid_q;
    logic [31:0]       waddr_q, waddr_d;
    logic [7:0]        wlen_q, wcnt_q;
    logic              wslverr_q, wslverr_d, wdecerr_q, wdecerr_d;
    logic              w_fire, w_final, w_oor;

    rstate_e           rstate_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [1:0]        rresp_q, rburst_q;
    logic [ID_W-1:0]   rid_q;
    logic [31:0]       raddr_q, raddr_d;
    logic [7:0]        rlen_q, rcnt_q;
    logic [DATA_W-1:0] rdata_q, rd_word;
    logic              r_oor;

    logic              unused_ok;
    assign unused_ok = ^{awsize, arsize};

`ifdef AXI_BRAM_RESPONDER_DECERR_EN
    assign w_oor = |waddr_q[31:DEPTH_LOG2+2];
    assign r_oor = |raddr_q[31:DEPTH_LOG2+2];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign w_fire    = (wstate_q == W_DATA) && wvalid && wready_q;
    assign w_final   = (wcnt_q == wlen_q);
    assign waddr_d   = next_addr(waddr_q, wburst_q);
    // wlast must coincide exactly with the beat-count terminal beat
    assign wslverr_d = wslverr_q | (wlast != w_final);
    assign wdecerr_d = wdecerr_q | w_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            wslverr_q <= 1'b0;
            wdecerr_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= awid;
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wburst_q  <= awburst;
                        wcnt_q    <= 8'd0;
                        wslverr_q <= 1'b0;
                        wdecerr_q <= 1'b0;
                        wstate_q  <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q   <= waddr_d;
                        wcnt_q    <= wcnt_q + 8'd1;
                        wslverr_q <= wslverr_d;
                        wdecerr_q <= wdecerr_d;
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= wdecerr_d ? 2'd3 : (wslverr_d ? 2'd2 : 2'd0);
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'd0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !w_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr_q[DEPTH_LOG2+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read port registers the next word whenever the current beat is consumed
    assign raddr_d = next_addr(raddr_q, rburst_q);
    assign rd_word = r_oor ? '0 : mem[raddr_q[DEPTH_LOG2+1:2]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'd0;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid;
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rburst_q  <= arburst;
                        rcnt_q    <= 8'd0;
                        rstate_q  <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    rdata_q  <= rd_word;
                    rresp_q  <= r_oor ? 2'd3 : 2'd0;
                    raddr_q  <= raddr_d;
                    rvalid_q <= 1'b1;
                    rlast_q  <= (rlen_q == 8'd0);
                    rstate_q <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= 2'd0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rdata_q <= rd_word;
                            rresp_q <= r_oor ? 2'd3 : 2'd0;
                            raddr_q <= raddr_d;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_bram_responder.sv
// tb/tb_axi_bram_responder.sv - directed self-checking bench for axi_bram_responder.
module tb_axi_bram_responder;
    localparam int ID_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH_LOG2 = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ID_W-1:0]   awid = '0, arid = '0, bid, rid;
    logic [31:0]       awaddr = '0, araddr = '0;
    logic [7:0]        awlen = '0, arlen = '0;
    logic [2:0]        awsize = 3'd2, arsize = 3'd2;
    logic [1:0]        awburst = 2'd1, arburst = 2'd1, bresp, rresp;
    logic              awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DATA_W-1:0] wdata = '0, rdata;
    logic [3:0]        wstrb = 4'hF;
    logic              bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic              rlast, rvalid, rready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [32];
    logic [1:0]  rrsp [32];
    logic        rlst [32];
    int          rcount, rgaps;
    logic [1:0]  last_bresp;
    logic [ID_W-1:0] last_bid;

    axi_bram_responder #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .reset(reset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [ID_W-1:0] id, input int last_at);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst; awvalid = 1'b1; bready = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL wr_aw_timeout awready=%0b expected 1", awready); end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL wr_wready_latency wready=%0b expected 1", wready); end
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == last_at);
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL wr_bvalid_latency bvalid=%0b expected 1", bvalid); end
        last_bresp = bresp; last_bid = bid;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL wr_bvalid_clear bvalid=%0b expected 0", bvalid); end
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [ID_W-1:0] id, input int mode);
        int t, k, stall_bad, rid_bad;
        logic have_prev, done, prev_last;
        logic [31:0] prev;
        rcount = 0; rgaps = 0; stall_bad = 0; rid_bad = 0; have_prev = 1'b0; done = 1'b0;
        prev = '0; prev_last = 1'b0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len[7:0]; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early rvalid=%0b expected 0", rvalid); end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_first_latency rvalid=%0b expected 1", rvalid); end
        k = 0;
        while (!done && k < 200) begin
            rready = (mode == 0) ? 1'b1 : k[0];
            if (rvalid) begin
                if (rid !== id) rid_bad++;
                if (have_prev && (rdata !== prev || rlast !== prev_last)) stall_bad++;
                if (rready) begin
                    if (rcount < 32) begin
                        rbuf[rcount] = rdata; rrsp[rcount] = rresp; rlst[rcount] = rlast;
                    end
                    rcount++;
                    have_prev = 1'b0;
                    if (rlast) done = 1'b1;
                end else begin
                    have_prev = 1'b1; prev = rdata; prev_last = rlast;
                end
            end else begin
                rgaps++;
            end
            @(negedge clk);
            k++;
        end
        rready = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL rd_timeout beats=%0d expected %0d", rcount, len + 1); end
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_clear rvalid=%0b expected 0", rvalid); end
        checks++;
        if (rid_bad != 0) begin errors++; $display("FAIL rd_rid bad_beats=%0d expected 0", rid_bad); end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL rd_stall_stable changes=%0d expected 0", stall_bad); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b expected 000000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bresp, rresp, bid, rid, rdata} !== '0) begin
            errors++; $display("FAIL reset_data bresp=%0d rresp=%0d bid=%0d rid=%0d rdata=%h expected all 0", bresp, rresp, bid, rid, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL reset_release awready/arready=%b expected 11", {awready, arready});
        end
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(32'h1000, 0, 2'd1, 4'd3, 0);
        checks++;
        if (last_bresp !== 2'd0 || last_bid !== 4'd3) begin
            errors++; $display("FAIL single_b bresp=%0d bid=%0d expected 0/3", last_bresp, last_bid);
        end
        do_read(32'h1000, 0, 2'd1, 4'd5, 0);
        checks++;
        if (rcount != 1 || rbuf[0] !== 32'hDEADBEEF || rlst[0] !== 1'b1 || rrsp[0] !== 2'd0) begin
            errors++; $display("FAIL single_r beats=%0d data=%h last=%0b resp=%0d expected 1/deadbeef/1/0", rcount, rbuf[0], rlst[0], rrsp[0]);
        end
    endtask

    task automatic test_strobes();
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(32'h0, 0, 2'd1, 4'd1, 0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
        do_write(32'h0, 0, 2'd1, 4'd1, 0);
        do_read(32'h0, 0, 2'd1, 4'd1, 0);
        checks++;
        if (rbuf[0] !== 32'h11BB33DD) begin
            errors++; $display("FAIL strobe_merge got %h expected 11bb33dd", rbuf[0]);
        end
    endtask

    task automatic test_incr_burst();
        for (int i = 0; i < 16; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; end
        do_write(32'h200, 15, 2'd1, 4'd7, 15);
        checks++;
        if (last_bresp !== 2'd0) begin errors++; $display("FAIL incr_bresp got %0d expected 0", last_bresp); end
        do_read(32'h200, 15, 2'd1, 4'd9, 0);
        checks++;
        if (rcount != 16 || rgaps != 0) begin
            errors++; $display("FAIL incr_throughput beats=%0d gaps=%0d expected 16/0", rcount, rgaps);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rbuf[i] !== i || rlst[i] !== (i == 15)) begin
                errors++; $display("FAIL incr_beat%0d data=%h last=%0b expected %h/%0b", i, rbuf[i], rlst[i], i, (i == 15));
            end
        end
    endtask

    task automatic test_backpressure();
        do_read(32'h200, 7, 2'd1, 4'd2, 1);
        checks++;
        if (rcount != 8) begin errors++; $display("FAIL bp_count got %0d expected 8", rcount); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbuf[i] !== i || rlst[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_beat%0d data=%h last=%0b expected %h/%0b", i, rbuf[i], rlst[i], i, (i == 7));
            end
        end
    endtask

    task automatic test_fixed();
        wbuf[0] = 32'h111; wbuf[1] = 32'h222; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(32'h400, 1, 2'd0, 4'd4, 1);
        do_read(32'h400, 0, 2'd1, 4'd4, 0);
        checks++;
        if (rbuf[0] !== 32'h222) begin errors++; $display("FAIL fixed_burst got %h expected 00000222", rbuf[0]); end
    endtask

    task automatic test_protocol_error();
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
        do_write(32'h300, 3, 2'd1, 4'd6, 1);
        checks++;
        if (last_bresp !== 2'd2) begin errors++; $display("FAIL early_wlast_bresp got %0d expected 2", last_bresp); end
        do_read(32'h300, 3, 2'd1, 4'd6, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rbuf[i] !== 32'hA0 + i) begin
                errors++; $display("FAIL early_wlast_beat%0d got %h expected %h", i, rbuf[i], 32'hA0 + i);
            end
        end
        do_write(32'h300, 3, 2'd1, 4'd6, -1);
        checks++;
        if (last_bresp !== 2'd2) begin errors++; $display("FAIL missing_wlast_bresp got %0d expected 2", last_bresp); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        awid = 4'd1; awaddr = 32'h800; awlen = 8'd0; awburst = 2'd1; awvalid = 1'b1;
        arid = 4'd2; araddr = 32'h200; arlen = 8'd7; arburst = 2'd1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        checks++;
        if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL mid_pre bvalid/rvalid=%b expected 11", {bvalid, rvalid}); end
        reset = 1'b1;
        #1;
        checks++;
        if ({bvalid, rvalid, awready, arready} !== 4'b0) begin
            errors++; $display("FAIL mid_reset_drop got %b expected 0000", {bvalid, rvalid, awready, arready});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL mid_release got %b expected 11", {awready, arready}); end
    endtask

    task automatic test_range();
        do_read(32'h4000, 0, 2'd1, 4'd8, 0);
`ifdef AXI_BRAM_RESPONDER_DECERR_EN
        checks++;
        if (rbuf[0] !== 32'h0 || rrsp[0] !== 2'd3) begin
            errors++; $display("FAIL oor_read data=%h resp=%0d expected 0/3", rbuf[0], rrsp[0]);
        end
`else
        checks++;
        if (rbuf[0] !== 32'h11BB33DD || rrsp[0] !== 2'd0) begin
            errors++; $display("FAIL alias_read data=%h resp=%0d expected 11bb33dd/0", rbuf[0], rrsp[0]);
        end
`endif
        wbuf[0] = 32'h5555; sbuf[0] = 4'hF;
        do_write(32'h4000, 0, 2'd1, 4'd8, 0);
        do_read(32'h0, 0, 2'd1, 4'd8, 0);
`ifdef AXI_BRAM_RESPONDER_DECERR_EN
        checks++;
        if (last_bresp !== 2'd3 || rbuf[0] !== 32'h11BB33DD) begin
            errors++; $display("FAIL oor_write bresp=%0d word0=%h expected 3/11bb33dd", last_bresp, rbuf[0]);
        end
`else
        checks++;
        if (last_bresp !== 2'd0 || rbuf[0] !== 32'h5555) begin
            errors++; $display("FAIL alias_write bresp=%0d word0=%h expected 0/00005555", last_bresp, rbuf[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobes();
        test_incr_burst();
        test_backpressure();
        test_fixed();
        test_protocol_error();
        test_reset_mid();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
